// File: rtl/prbs_checker.sv
// Receive-side checker for the 32-bit LFSR word stream (new LSB = w[31] ^ w[21]).
// Self-synchronises, declares lock, then counts word and bit errors with saturation.
module prbs_checker #(
    parameter int LOCK_MATCHES = 8,
    parameter int LOSS_MISSES  = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             data_valid,
    input  logic [31:0]      data_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic [1:0]       state
);

    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int MISS_W  = $clog2(LOSS_MISSES + 1);
    localparam int SUM_W   = CNT_W + 6;

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_MISSES - 1);
    localparam logic [SUM_W-1:0]   CNT_MAX    = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pred_q, pred_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]   bit_q, bit_d;

    logic               lock_miss;
    logic [5:0]         miss_bits;
    logic [SUM_W-1:0]   bit_sum;

    function automatic logic [31:0] prbs_next(input logic [31:0] p);
        return {p[30:0], p[31] ^ p[21]};
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] d);
        logic [5:0] pc;
        pc = '0;
        for (int i = 0; i < 32; i++) pc = pc + 6'(d[i]);
        return pc;
    endfunction

    // NOTE: state lives only in this block and is updated with <=, so every
    // register samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            pred_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            word_q   <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
        end
    end

    // NOTE: every comb output gets a hold default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        match_d   = match_q;
        miss_d    = miss_q;
        lock_miss = 1'b0;
        if (data_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    // An all-zero word is the LFSR lock-up state and cannot seed.
                    if (data_in != '0) begin
                        pred_d  = prbs_next(data_in);
                        match_d = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (data_in == pred_q) begin
                        pred_d = prbs_next(pred_q);
                        if (match_q == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else if (data_in == '0) begin
                        state_d = ST_HUNT;
                    end else begin
                        pred_d  = prbs_next(data_in);
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running predictor: a corrupted word never re-seeds it.
                    pred_d = prbs_next(pred_q);
                    if (data_in == pred_q) begin
                        miss_d = '0;
                    end else begin
                        lock_miss = 1'b1;
                        if (miss_q == MISS_LAST) begin
                            state_d = ST_HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign miss_bits = popcount32(data_in ^ pred_q);
    assign bit_sum   = SUM_W'(bit_q) + SUM_W'(miss_bits);

    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        err_d    = lock_miss;
        word_d   = word_q;
        bit_d    = bit_q;
        if (clear) begin
            word_d = '0;
            bit_d  = '0;
        end else if (lock_miss) begin
            if (word_q != '1) word_d = word_q + CNT_W'(1);
            bit_d = (bit_sum > CNT_MAX) ? '1 : bit_sum[CNT_W-1:0];
        end
    end

    assign locked         = locked_q;
    assign err_pulse      = err_q;
    assign word_err_count = word_q;
    assign bit_err_count  = bit_q;
    assign state          = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: acquisition, error counting, loss/relock,
// valid gaps, saturation (second instance with CNT_W=4), clear and async reset.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;

    logic        a_locked, a_err;
    logic [15:0] a_wec, a_bec;
    logic [1:0]  a_state;
    logic        b_locked, b_err;
    logic [3:0]  b_wec, b_bec;
    logic [1:0]  b_state;

    prbs_checker dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_valid(data_valid), .data_in(data_in),
        .locked(a_locked), .err_pulse(a_err), .word_err_count(a_wec),
        .bit_err_count(a_bec), .state(a_state)
    );

    prbs_checker #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_valid(data_valid), .data_in(data_in),
        .locked(b_locked), .err_pulse(b_err), .word_err_count(b_wec),
        .bit_err_count(b_bec), .state(b_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] g;
    int          exp_b;
    int          n_valid;
    int          exp_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] p);
        return {p[30:0], p[31] ^ p[21]};
    endfunction

    task automatic send(input logic v, input logic [31:0] d, input logic clr);
        data_valid = v;
        data_in    = d;
        clear      = clr;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic good();
        send(1'b1, g, 1'b0);
        g = nxt(g);
    endtask

    task automatic bad(input logic [31:0] mask);
        send(1'b1, g ^ mask, 1'b0);
        g = nxt(g);
    endtask

    task automatic acquire(input string tag);
        for (int i = 1; i <= 9; i++) begin
            good();
            if (i == 1) check({tag, "_seed_state"}, 32'(a_state), 32'd1);
            if (i == 8) begin
                check({tag, "_8_locked"}, 32'(a_locked), 32'd0);
                check({tag, "_8_state"}, 32'(a_state), 32'd1);
            end
            if (i == 9) begin
                check({tag, "_9_locked"}, 32'(a_locked), 32'd1);
                check({tag, "_9_state"}, 32'(a_state), 32'd2);
            end
        end
    endtask

    initial begin
        #8;
        check("rst_locked", 32'(a_locked), 32'd0);
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_wec", 32'(a_wec), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        #4 rst_n = 1'b1;

        // Clean acquisition from seed 0x1.
        g = 32'h0000_0001;
        acquire("acq");
        check("acq_wec", 32'(a_wec), 32'd0);
        check("acq_bec", 32'(a_bec), 32'd0);

        // Single bit flip while locked.
        bad(32'h0000_0020);
        check("flip_err", 32'(a_err), 32'd1);
        check("flip_wec", 32'(a_wec), 32'd1);
        check("flip_bec", 32'(a_bec), 32'd1);
        check("flip_locked", 32'(a_locked), 32'd1);
        for (int i = 0; i < 3; i++) begin
            good();
            check("after_flip_err", 32'(a_err), 32'd0);
        end
        check("after_flip_wec", 32'(a_wec), 32'd1);
        check("after_flip_locked", 32'(a_locked), 32'd1);

        // Clear on an invalid cycle, then four garbage words force loss of lock.
        send(1'b0, 32'hFFFF_FFFF, 1'b1);
        check("clear_wec", 32'(a_wec), 32'd0);
        check("clear_bec", 32'(a_bec), 32'd0);
        check("clear_locked", 32'(a_locked), 32'd1);
        exp_b = 0;
        for (int k = 0; k < 4; k++) begin
            exp_b += $countones(32'hDEAD_BEEF ^ g);
            send(1'b1, 32'hDEAD_BEEF, 1'b0);
            g = nxt(g);
            check("loss_wec", 32'(a_wec), 32'(k + 1));
            check("loss_bec", 32'(a_bec), 32'(exp_b));
            check("loss_locked", 32'(a_locked), (k < 3) ? 32'd1 : 32'd0);
            check("loss_state", 32'(a_state), (k < 3) ? 32'd2 : 32'd0);
        end
        acquire("relock");
        check("relock_wec", 32'(a_wec), 32'd4);

        // Acquisition and lock with random valid gaps.
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        g = 32'h1234_5678;
        n_valid = 0;
        for (int c = 0; c < 200 && n_valid < 9; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                good();
                n_valid++;
            end else begin
                send(1'b0, 32'hA5A5_A5A5, 1'b0);
                check("gap_err", 32'(a_err), 32'd0);
            end
            exp_state = (n_valid == 0) ? 0 : (n_valid < 9) ? 1 : 2;
            check("gap_state", 32'(a_state), 32'(exp_state));
            check("gap_locked", 32'(a_locked), (n_valid == 9) ? 32'd1 : 32'd0);
        end
        check("gap_budget", 32'(n_valid), 32'd9);
        for (int c = 0; c < 30; c++) begin
            if ($urandom_range(0, 1) == 1) good();
            else send(1'b0, 32'h0F0F_0F0F, 1'b0);
            check("gap_lock_err", 32'(a_err), 32'd0);
            check("gap_lock_locked", 32'(a_locked), 32'd1);
        end
        check("gap_wec", 32'(a_wec), 32'd0);

        // Saturation: 20 single-bit errors interleaved with good words.
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        g = 32'h0000_0001;
        acquire("sat_acq");
        for (int i = 0; i < 20; i++) begin
            bad(32'h1 << (i % 32));
            good();
            if (i == 14) check("sat_b_wec_15", 32'(b_wec), 32'd15);
        end
        check("sat_b_wec", 32'(b_wec), 32'd15);
        check("sat_b_bec", 32'(b_bec), 32'd15);
        check("sat_a_wec", 32'(a_wec), 32'd20);
        check("sat_a_bec", 32'(a_bec), 32'd20);
        check("sat_b_locked", 32'(b_locked), 32'd1);

        send(1'b0, 32'h0, 1'b1);
        bad(32'hFFFF_FFFF);
        check("wide_b_bec", 32'(b_bec), 32'd15);
        check("wide_a_bec", 32'(a_bec), 32'd32);
        check("wide_b_wec", 32'(b_wec), 32'd1);
        good();

        send(1'b1, g ^ 32'h1, 1'b1);
        g = nxt(g);
        check("clr_err_pulse", 32'(b_err), 32'd1);
        check("clr_b_wec", 32'(b_wec), 32'd0);
        check("clr_b_bec", 32'(b_bec), 32'd0);
        check("clr_a_wec", 32'(a_wec), 32'd0);
        good();
        check("clr_after_err", 32'(b_err), 32'd0);

        // Asynchronous reset between clock edges while locked.
        bad(32'h0000_0003);
        check("pre_rst_err", 32'(a_err), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(a_locked), 32'd0);
        check("arst_err", 32'(a_err), 32'd0);
        check("arst_state", 32'(a_state), 32'd0);
        check("arst_wec", 32'(a_wec), 32'd0);
        check("arst_bec", 32'(a_bec), 32'd0);
        check("arst_b_locked", 32'(b_locked), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'h0, 1'b0);
            check("zero_hunt_state", 32'(a_state), 32'd0);
            check("zero_hunt_locked", 32'(a_locked), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
